// File: rtl/l1c_data_param.sv
// Direct-mapped, write-through / no-write-allocate L1 data cache with an uncacheable window.
// Define L1C_DATA_STATS_EN to add the saturating hit_cnt / miss_cnt statistics outputs.
module l1c_data_param #(
  parameter int          INDEX_BITS        = 6,
  parameter int          OFFSET_WORDS_BITS = 2,
  parameter logic [15:0] UNCACHED_HI       = 16'h1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] core_addr,
  input  logic        core_req,
  input  logic        core_write,
  input  logic [31:0] core_in,
  input  logic [2:0]  core_type,
  input  logic [31:0] D_out,
  input  logic        D_wait,
  output logic [31:0] core_out,
  output logic        core_wait,
  output logic        D_req,
  output logic        D_write,
  output logic [31:0] D_addr,
  output logic [31:0] D_in,
  output logic [2:0]  D_type
`ifdef L1C_DATA_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int OFF_W  = OFFSET_WORDS_BITS;
  localparam int IDX_LO = OFF_W + 2;
  localparam int TAG_LO = INDEX_BITS + OFF_W + 2;
  localparam int TAG_W  = 32 - TAG_LO;
  localparam int LINES  = 1 << INDEX_BITS;
  localparam int WORDS  = 1 << (INDEX_BITS + OFF_W);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, REFILL, UNCACHED, WRITE, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         addr_q, in_q, rdata_q;
  logic [2:0]          type_q;
  logic                write_q, hit_q;
  logic [OFF_W-1:0]    beat_q;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [31:0]         data_mem [WORDS];

  logic [INDEX_BITS-1:0] idx;
  logic [OFF_W-1:0]      woff;
  logic                  cacheable, lookup_hit, xfer_done, last_beat;

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   byte_en = 4'b0001 << a;
      2'b01:   byte_en = a[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    merge_word = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) merge_word[8*b +: 8] = new_w[8*b +: 8];
  endfunction

  assign idx        = addr_q[TAG_LO-1:IDX_LO];
  assign woff       = addr_q[IDX_LO-1:2];
  assign cacheable  = (addr_q[31:16] != UNCACHED_HI);
  assign lookup_hit = valid_q[idx] && (tag_mem[idx] == addr_q[31:TAG_LO]) && cacheable;
  assign xfer_done  = D_req && !D_wait;
  assign last_beat  = (beat_q == {OFF_W{1'b1}});

  always_comb begin
    state_d   = state_q;
    core_wait = 1'b1;
    core_out  = 32'd0;
    D_req     = 1'b0;
    D_write   = 1'b0;
    D_addr    = 32'd0;
    D_in      = 32'd0;
    D_type    = type_q;
    unique case (state_q)
      IDLE: begin
        core_wait = core_req;
        D_type    = 3'b000;
        if (core_req) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (write_q)         state_d = WRITE;
        else if (lookup_hit) state_d = DONE;
        else if (cacheable)  state_d = REFILL;
        else                 state_d = UNCACHED;
      end
      REFILL: begin
        D_req  = 1'b1;
        D_addr = {addr_q[31:IDX_LO], beat_q, 2'b00};
        if (!D_wait && last_beat) state_d = DONE;
      end
      UNCACHED: begin
        D_req  = 1'b1;
        D_addr = addr_q;
        if (!D_wait) state_d = DONE;
      end
      WRITE: begin
        D_req   = 1'b1;
        D_write = 1'b1;
        D_addr  = addr_q;
        D_in    = in_q;
        if (!D_wait) state_d = DONE;
      end
      DONE: begin
        core_wait = 1'b0;
        core_out  = write_q ? 32'd0 : rdata_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, request latches, valid bits, refill beat, read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      in_q    <= 32'd0;
      type_q  <= 3'b000;
      write_q <= 1'b0;
      hit_q   <= 1'b0;
      beat_q  <= '0;
      valid_q <= '0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && core_req) begin
        addr_q  <= core_addr;
        in_q    <= core_in;
        type_q  <= core_type;
        write_q <= core_write;
      end
      if (state_q == LOOKUP) begin
        hit_q   <= lookup_hit;
        rdata_q <= data_mem[{idx, woff}];
      end
      if (state_q == REFILL && xfer_done) begin
        beat_q <= beat_q + 1'b1;
        if (beat_q == woff) rdata_q <= D_out;
        if (last_beat) valid_q[idx] <= 1'b1;
      end
      if (state_q == UNCACHED && xfer_done) rdata_q <= D_out;
    end
  end

  // Line storage: refill beats fill words in order; write hits merge only enabled bytes
  always_ff @(posedge clk) begin
    if (state_q == REFILL && xfer_done) begin
      data_mem[{idx, beat_q}] <= D_out;
      if (last_beat) tag_mem[idx] <= addr_q[31:TAG_LO];
    end else if (state_q == WRITE && xfer_done && hit_q) begin
      data_mem[{idx, woff}] <= merge_word(data_mem[{idx, woff}], in_q,
                                          byte_en(type_q[1:0], addr_q[1:0]));
    end
  end

`ifdef L1C_DATA_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else if (state_q == LOOKUP && !write_q && cacheable) begin
      if (lookup_hit) hit_cnt  <= sat_inc(hit_cnt);
      else            miss_cnt <= sat_inc(miss_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_l1c_data_param.sv
// Self-checking bench for l1c_data_param: vector table plus reset corner sequences.
module tb_l1c_data_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] core_addr, core_in, D_out, core_out, D_addr, D_in;
  logic        core_req, core_write, D_wait, core_wait, D_req, D_write;
  logic [2:0]  core_type, D_type;
`ifdef L1C_DATA_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  l1c_data_param dut (
    .clk(clk), .rst(rst), .core_addr(core_addr), .core_req(core_req),
    .core_write(core_write), .core_in(core_in), .core_type(core_type),
    .D_out(D_out), .D_wait(D_wait), .core_out(core_out), .core_wait(core_wait),
    .D_req(D_req), .D_write(D_write), .D_addr(D_addr), .D_in(D_in), .D_type(D_type)
`ifdef L1C_DATA_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    logic [2:0]  typ;
    int          wcyc;
    logic [31:0] ucd;
    int          lat;
    int          nx;
  } req_t;

  typedef struct {
    logic [31:0] out;
    int          lat;
    int          nx;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] tb_mem [logic [31:0]];
  int          n_chk = 0;
  int          n_fail = 0;
  int          wait_cycles = 0;
  logic [31:0] uc_data = 32'd0;
  int          exp_hit = 0;
  int          exp_miss = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    if (tb_mem.exists(k)) return tb_mem[k];
    return (k * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic void mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    logic [31:0] w;
    w = mem_rd(a);
    if (t[1:0] == 2'b00)      w[8*a[1:0] +: 8] = d[8*a[1:0] +: 8];
    else if (t[1:0] == 2'b01) w[16*a[1] +: 16] = d[16*a[1] +: 16];
    else                      w = d;
    tb_mem[{a[31:2], 2'b00}] = w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory responder: per beat, wait_cycles stall cycles then one completing cycle
  initial begin
    int cnt;
    cnt = 0;
    D_wait = 1'b0;
    D_out = 32'd0;
    forever begin
      @(negedge clk);
      if (D_req) begin
        D_out = (D_addr[31:16] == 16'h1000) ? uc_data : mem_rd(D_addr);
        if (cnt < wait_cycles) begin
          D_wait = 1'b1;
          cnt++;
        end else begin
          D_wait = 1'b0;
          cnt = 0;
          if (D_write) mem_wr(D_addr, D_in, D_type);
        end
      end else begin
        D_wait = 1'b0;
        cnt = 0;
      end
    end
  end

  task automatic run_req(input req_t r);
    sb_t         e;
    int          lat, nx;
    bit          done;
    logic [31:0] ea;
    wait_cycles = r.wcyc;
    uc_data     = r.ucd;
    @(negedge clk);
    core_addr = r.addr; core_write = r.wr; core_in = r.data; core_type = r.typ;
    core_req  = 1'b1;
    e.out = r.wr ? 32'd0 : ((r.addr[31:16] == 16'h1000) ? r.ucd : mem_rd(r.addr));
    e.lat = r.lat;
    e.nx  = r.nx;
    sb.push_back(e);
    if (!r.wr && r.addr[31:16] != 16'h1000) begin
      if (r.nx == 0) exp_hit++;
      else           exp_miss++;
    end
    #1;
    chk("idle_core_wait", core_wait, 1'b1);
    chk("idle_core_out", core_out, 32'd0);
    chk("idle_d_req", D_req, 1'b0);
    @(posedge clk);
    lat = 0; nx = 0; done = 0;
    while (!done && lat < 300) begin
      @(negedge clk);
      core_req = 1'b0;
      #2;
      lat++;
      if (D_req) begin
        ea = (!r.wr && r.addr[31:16] != 16'h1000) ? {r.addr[31:4], nx[1:0], 2'b00} : r.addr;
        chk("d_addr", D_addr, ea);
        chk("d_write", D_write, r.wr);
        chk("d_type", D_type, r.typ);
        if (r.wr) chk("d_in", D_in, r.data);
        if (!D_wait) nx++;
      end
      if (!core_wait) begin
        done = 1;
        e = sb.pop_front();
        chk("latency", lat, e.lat);
        chk("mem_beats", nx, e.nx);
        if (!r.wr) chk("core_out", core_out, e.out);
      end
    end
    if (!done) begin
      void'(sb.pop_front());
      n_chk++;
      n_fail++;
      $display("FAIL timeout: addr %h still waiting after %0d cycles", r.addr, lat);
    end
  endtask

  function automatic req_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                              input logic [2:0] t, input int wc, input logic [31:0] u,
                              input int l, input int n);
    req_t r;
    r.addr = a; r.wr = w; r.data = d; r.typ = t; r.wcyc = wc; r.ucd = u; r.lat = l; r.nx = n;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t tbl [21];
    int   cyc, nx;
    tbl[0]  = mk(32'h0000_0040, 0, 0,            3'b010, 0, 0,            6,  4);
    tbl[1]  = mk(32'h0000_0040, 0, 0,            3'b010, 0, 0,            2,  0);
    tbl[2]  = mk(32'h0000_0048, 0, 0,            3'b010, 0, 0,            2,  0);
    tbl[3]  = mk(32'h0000_0041, 1, 32'h0000_AB00, 3'b000, 0, 0,           3,  1);
    tbl[4]  = mk(32'h0000_0040, 0, 0,            3'b010, 0, 0,            2,  0);
    tbl[5]  = mk(32'h0000_004E, 1, 32'hCAFE_0000, 3'b001, 0, 0,           3,  1);
    tbl[6]  = mk(32'h0000_004C, 0, 0,            3'b010, 0, 0,            2,  0);
    tbl[7]  = mk(32'h0000_0044, 1, 32'h1122_3344, 3'b010, 0, 0,           3,  1);
    tbl[8]  = mk(32'h0000_0044, 0, 0,            3'b010, 0, 0,            2,  0);
    tbl[9]  = mk(32'h0000_0400, 1, 32'hDEAD_BEEF, 3'b010, 0, 0,           3,  1);
    tbl[10] = mk(32'h0000_0400, 0, 0,            3'b010, 0, 0,            6,  4);
    tbl[11] = mk(32'h1000_0008, 0, 0,            3'b010, 0, 32'h1234_5678, 3,  1);
    tbl[12] = mk(32'h1000_0008, 0, 0,            3'b010, 0, 32'h0000_0001, 3,  1);
    tbl[13] = mk(32'h0000_0080, 0, 0,            3'b010, 5, 0,            26, 4);
    tbl[14] = mk(32'h0000_0084, 0, 0,            3'b010, 0, 0,            2,  0);
    tbl[15] = mk(32'h0000_0440, 0, 0,            3'b010, 0, 0,            6,  4);
    tbl[16] = mk(32'h0000_0040, 0, 0,            3'b010, 0, 0,            6,  4);
    tbl[17] = mk(32'h1000_0010, 1, 32'h5566_7788, 3'b010, 0, 0,           3,  1);
    tbl[18] = mk(32'h0000_00CC, 0, 0,            3'b010, 2, 0,            14, 4);
    tbl[19] = mk(32'h0000_004D, 1, 32'h0000_EE00, 3'b100, 0, 0,           3,  1);
    tbl[20] = mk(32'h0000_004C, 0, 0,            3'b010, 0, 0,            2,  0);

    rst = 1'b1; core_req = 1'b0; core_write = 1'b0; core_addr = 32'd0;
    core_in = 32'd0; core_type = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    chk("rst_core_wait", core_wait, 1'b0);
    chk("rst_core_out", core_out, 32'd0);
    chk("rst_d_req", D_req, 1'b0);
    chk("rst_d_addr", D_addr, 32'd0);
    chk("rst_d_type", D_type, 3'b000);
    chk("rst_d_in_write", {D_in[30:0], D_write}, 32'd0);
    core_req = 1'b1;
    #1 chk("rst_core_wait_follows_req", core_wait, 1'b1);
    @(negedge clk);
    core_req = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 21; i++) run_req(tbl[i]);

`ifdef L1C_DATA_STATS_EN
    @(negedge clk); #2;
    chk("hit_cnt", hit_cnt, exp_hit);
    chk("miss_cnt", miss_cnt, exp_miss);
`endif

    // Reset during the third refill beat
    wait_cycles = 3;
    @(negedge clk);
    core_addr = 32'h0000_0200; core_write = 1'b0; core_type = 3'b010; core_req = 1'b1;
    @(posedge clk);
    nx = 0; cyc = 0;
    while (nx < 2 && cyc < 200) begin
      @(negedge clk);
      core_req = 1'b0;
      #2;
      cyc++;
      if (D_req && !D_wait) nx++;
    end
    chk("rst_seq_beats", nx, 2);
    @(posedge clk);
    @(negedge clk);
    #2 chk("beat2_d_req", D_req, 1'b1);
    chk("beat2_d_addr", D_addr, 32'h0000_0208);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #2;
    chk("rst_mid_refill_d_req", D_req, 1'b0);
    chk("rst_mid_refill_core_wait", core_wait, 1'b0);
`ifdef L1C_DATA_STATS_EN
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif
    rst = 1'b0;

    run_req(mk(32'h0000_0200, 0, 0, 3'b010, 3, 0, 18, 4));
    run_req(mk(32'h0000_0040, 0, 0, 3'b010, 0, 0, 6, 4));
    run_req(mk(32'h0000_0040, 0, 0, 3'b010, 0, 0, 2, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
